// File: rtl/apb_master_bridge_if.sv
// Bundle of signals for apb_master_bridge.
// It carries three groups: the command port, the response port and the APB bus.
//
// Handshake rule for the cmd and rsp ports:
//   A transfer happens at a rising edge where both valid and ready are 1.
//   Once valid is raised, the payload is held stable until that edge.
//   The bridge never makes cmd_ready or rsp_valid depend on the partner's
//   valid or ready in the same cycle.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // command port
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    // response port
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    // APB bus
    logic                      PSELx;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    // Bridge side: drives cmd_ready, the response and the APB request signals.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    // Environment side: the command source, the response sink and the APB slave.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester for one outstanding command.
// A command accepted on the cmd port is run through the APB SETUP and ACCESS
// phases. The result is then presented on the rsp port until it is consumed.
// A watchdog aborts an ACCESS phase that never sees PREADY.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_bridge_if.master  bus,
    output logic [1:0]           fsm_state
);
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic [CNT_WIDTH-1:0]   wait_cnt_next;

    // The count this ACCESS cycle would reach if PREADY stays low.
    assign wait_cnt_next = wait_cnt + CNT_ONE;

    // Expose the FSM state for debug and checkers.
    assign fsm_state = state;

    // Main FSM. Every bus and response output is a register here.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWDATA      <= '0;
            bus.PSTRB       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is always 1 here, so cmd_valid alone means the
                    // command is accepted.
                    if (bus.cmd_valid) begin
                        bus.PADDR     <= bus.cmd_addr;
                        bus.PWRITE    <= bus.cmd_write;
                        bus.PWDATA    <= bus.cmd_wdata;
                        bus.PSTRB     <= bus.cmd_write ? bus.cmd_strb : '0;
                        bus.PSELx     <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first, so it wins over a watchdog
                    // expiry on the same edge.
                    if (bus.PREADY) begin
                        bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
                        bus.rsp_err     <= bus.PSLVERR;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.PSELx       <= 1'b0;
                        bus.PENABLE     <= 1'b0;
                        state           <= RESP;
                    end else if (wait_cnt_next == CNT_LIMIT) begin
                        wait_cnt        <= wait_cnt_next;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        bus.PSELx       <= 1'b0;
                        bus.PENABLE     <= 1'b0;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge, built with TIMEOUT_CYCLES=4.
// The bench plays three roles: the command source, the response sink and
// the APB slave.
module tb_apb_master_bridge;
    logic       PCLK;
    logic       PRESET;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses, packed as {timeout, err, rdata}.
    logic [33:0] exp_q[$];

    apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Pop the next expected response and compare it with the rsp port.
    task automatic check_rsp(input string tag);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"},   bus.rsp_rdata,   e[31:0]);
            check({tag, "_err"},     bus.rsp_err,     e[32]);
            check({tag, "_timeout"}, bus.rsp_timeout, e[33]);
        end
    endtask

    // Issue one command and act as the slave until rsp_valid shows up.
    // PREADY rises in ACCESS cycle number waits+1. Waits of 99 or more
    // never see PREADY. While PREADY is low, PSLVERR and PRDATA carry noise
    // that the bridge must ignore.
    // lat : cycles from the accept cycle to the first rsp_valid cycle
    // pen : number of cycles with PENABLE high
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input logic slverr,
                        input logic [31:0] rdata, output int lat, output int pen);
        logic bad;
        bad         = 1'b0;
        lat         = 0;
        pen         = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        for (int g = 0; g < 10 && !bus.cmd_ready; g++) tick();
        check("cmd_ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        lat = 1;
        check("setup_sel_en", {bus.PSELx, bus.PENABLE}, 2'b10);
        check("setup_cmd_ready", bus.cmd_ready, 0);
        for (int i = 0; i < 60 && !bus.rsp_valid; i++) begin
            if (bus.PENABLE) begin
                pen++;
                if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PSELx !== 1'b1 ||
                    bus.PSTRB !== (wr ? strb : 4'h0) || (wr && bus.PWDATA !== wdata))
                    bad = 1'b1;
                bus.PREADY  = (pen > waits);
                bus.PSLVERR = bus.PREADY ? slverr : 1'b1;
                bus.PRDATA  = bus.PREADY ? rdata : 32'hBAD0_0BAD;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b1;
            end
            tick();
            lat++;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        check("rsp_valid_arrived", bus.rsp_valid, 1);
        check("access_bus_stable", bad, 0);
        check("resp_sel_en", {bus.PSELx, bus.PENABLE}, 2'b00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  lat;
        int  pen;
        logic bad;
        logic seen;

        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_strb  = 4'h0;
        bus.rsp_ready = 1'b1;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        #1;
        // Check the reset values of the outputs.
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_sel_en", {bus.PSELx, bus.PENABLE}, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_rsp", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 0);
        check("rst_state", fsm_state, 0);
        tick();
        tick();
        PRESET = 1'b0;
        tick();

        // 1. Zero-wait write. Expected timeline: accept cycle, SETUP, ACCESS,
        //    then RESP, which is 3 cycles after the accept cycle.
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        xfer(1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, lat, pen);
        check("t1_latency", lat, 3);
        check("t1_penable_cycles", pen, 1);
        check_rsp("t1");
        tick();
        check("t1_back_idle", {bus.rsp_valid, bus.cmd_ready, fsm_state}, {1'b0, 1'b1, 2'd0});
        check("t1_paddr_held", bus.PADDR, 32'h04);

        // 2. Read with 2 wait states. PSTRB must be forced to 0, and the
        //    PSLVERR noise during the waits must be ignored.
        exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 2, 1'b0, 32'hDEAD_BEEF, lat, pen);
        check("t2_penable_cycles", pen, 3);
        check("t2_latency", lat, 5);
        check_rsp("t2");
        tick();

        // 3. Write that gets PSLVERR together with PREADY.
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        xfer(1'b1, 32'h40, 32'h1234_5678, 4'h3, 1, 1'b1, 32'h0, lat, pen);
        check("t3_penable_cycles", pen, 2);
        check_rsp("t3");
        tick();

        // 4a. PREADY never comes. The watchdog aborts after 4 ACCESS cycles.
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 99, 1'b0, 32'h0, lat, pen);
        check("t4_penable_cycles", pen, 4);
        check("t4_latency", lat, 6);
        check_rsp("t4");
        tick();

        // 4b. PREADY arrives in the 4th ACCESS cycle. It beats the watchdog.
        exp_q.push_back({1'b0, 1'b0, 32'h1357_9BDF});
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, 3, 1'b0, 32'h1357_9BDF, lat, pen);
        check("t4b_penable_cycles", pen, 4);
        check_rsp("t4b");
        tick();

        // 5. Response back-pressure. A new command offered while the bridge
        //    is busy must be ignored.
        bus.rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'hA5A5_5A5A});
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_5A5A, lat, pen);
        bad = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h80;
        bus.cmd_wdata = 32'hFFFF_FFFF;
        bus.cmd_strb  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA5A5_5A5A ||
                bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.PSELx !== 1'b0)
                bad = 1'b1;
        end
        check("t5_hold_stable", bad, 0);
        check_rsp("t5");
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("t5_released", {bus.rsp_valid, bus.cmd_ready, fsm_state}, {1'b0, 1'b1, 2'd0});
        check("t5_paddr_not_taken", bus.PADDR, 32'h10);

        // 6. Reset asserted in the middle of ACCESS.
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h20;
        bus.cmd_wdata = 32'h0F0F_0F0F;
        bus.cmd_strb  = 4'hF;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("t6_in_access", {bus.PSELx, bus.PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1;
        check("t6_async_sel_en", {bus.PSELx, bus.PENABLE}, 2'b00);
        check("t6_async_rsp_cmd", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        check("t6_async_paddr", bus.PADDR, 0);
        tick();
        PRESET = 1'b0;
        bus.PREADY = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        bus.PREADY = 1'b0;
        check("t6_no_response", seen, 0);
        check("t6_idle", {fsm_state, bus.cmd_ready}, {2'd0, 1'b1});

        // A normal transfer after the reset still completes.
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        xfer(1'b1, 32'h44, 32'hCAFE_F00D, 4'h5, 0, 1'b0, 32'h0, lat, pen);
        check("t7_latency", lat, 3);
        check_rsp("t7");
        tick();

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
